// File: rtl/spatz_pkg.sv
// Shared Spatz types used by the vector controller datapath.
// NrVrfWriters is the number of units that share the VRF write port.
package spatz_pkg;

    localparam int unsigned NrVrfWriters = 2;

    typedef logic [9:0]  vreg_addr_t;
    typedef logic [63:0] vreg_data_t;
    typedef logic [7:0]  vreg_be_t;
    typedef logic [2:0]  spatz_id_t;

endpackage

// File: rtl/spatz_vrf_arb_starve_ctr.sv
// Per-requester wait counter: counts lost cycles while a request is pending
// and saturates at the threshold, which marks the requester as starved.
module spatz_vrf_arb_starve_ctr #(
    parameter int unsigned ThW = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           req_i,
    input  logic           grant_i,
    input  logic [ThW-1:0] thresh_i,
    output logic           starved_o
);

    logic [ThW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || grant_i) begin
            cnt_d = '0;
        end else if (cnt_q < thresh_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q >= thresh_i);

endmodule

// File: rtl/spatz_vrf_wport_arbiter.sv
// Round-robin arbiter with starvation override sharing one VRF write port;
// the winner is held in a one-entry output register. Optional statistics
// counters are built when SPATZ_VRF_ARB_STATS_EN is defined.
module spatz_vrf_wport_arbiter
    import spatz_pkg::*;
#(
    parameter int unsigned NrReq        = NrVrfWriters,
    parameter int unsigned StarveThresh = 8,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic       [NrReq-1:0]         req_we_i,
    input  vreg_addr_t [NrReq-1:0]         req_waddr_i,
    input  vreg_data_t [NrReq-1:0]         req_wdata_i,
    input  vreg_be_t   [NrReq-1:0]         req_wbe_i,
    input  spatz_id_t  [NrReq-1:0]         req_id_i,
    output logic       [NrReq-1:0]         req_wvalid_o,
    output logic                           vrf_we_o,
    output vreg_addr_t                     vrf_waddr_o,
    output vreg_data_t                     vrf_wdata_o,
    output vreg_be_t                       vrf_wbe_o,
    output spatz_id_t                      vrf_id_o,
    input  logic                           vrf_wvalid_i,
    output logic [NrReq-1:0][CntWidth-1:0] stat_grant_o,
    output logic [NrReq-1:0][CntWidth-1:0] stat_stall_o
);

    localparam int unsigned PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int unsigned CW   = PtrW + 1;
    localparam int unsigned ThW  = $clog2(StarveThresh + 1);

    logic             out_valid_q, out_valid_d;
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    vreg_addr_t       waddr_q;
    vreg_data_t       wdata_q;
    vreg_be_t         wbe_q;
    spatz_id_t        id_q;

    logic [NrReq-1:0] starved;
    logic [NrReq-1:0] gnt;
    logic             cap;
    logic             win_found;
    logic [PtrW-1:0]  win_idx;
    logic [CW-1:0]    cand;

    for (genvar i = 0; i < NrReq; i++) begin : g_starve
        spatz_vrf_arb_starve_ctr #(
            .ThW(ThW)
        ) i_starve_ctr (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .req_i    (req_we_i[i]),
            .grant_i  (gnt[i]),
            .thresh_i (ThW'(StarveThresh)),
            .starved_o(starved[i])
        );
    end

    // Starved requesters pre-empt the round-robin search, lowest index first.
    always_comb begin
        cap       = ~out_valid_q | vrf_wvalid_i;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NrReq; i++) begin
            if (!win_found && req_we_i[i] && starved[i]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(i);
            end
        end
        for (int k = 0; k < NrReq; k++) begin
            cand = CW'(rr_ptr_q) + CW'(k);
            if (cand >= CW'(NrReq)) begin
                cand = cand - CW'(NrReq);
            end
            if (!win_found && req_we_i[cand[PtrW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PtrW-1:0];
            end
        end

        gnt = '0;
        if (cap && win_found) begin
            gnt[win_idx] = 1'b1;
        end

        out_valid_d = cap ? win_found : out_valid_q;
        rr_ptr_d    = (win_idx == PtrW'(NrReq - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (|gnt) begin
                rr_ptr_q <= rr_ptr_d;
            end
        end
    end

    // Payload needs no reset: every output field is masked while empty.
    always_ff @(posedge clk_i) begin
        if (|gnt) begin
            waddr_q <= req_waddr_i[win_idx];
            wdata_q <= req_wdata_i[win_idx];
            wbe_q   <= req_wbe_i[win_idx];
            id_q    <= req_id_i[win_idx];
        end
    end

    assign req_wvalid_o = gnt;
    assign vrf_we_o     = out_valid_q;
    assign vrf_waddr_o  = out_valid_q ? waddr_q : '0;
    assign vrf_wdata_o  = out_valid_q ? wdata_q : '0;
    assign vrf_wbe_o    = out_valid_q ? wbe_q   : '0;
    assign vrf_id_o     = out_valid_q ? id_q    : '0;

`ifdef SPATZ_VRF_ARB_STATS_EN
    logic [NrReq-1:0][CntWidth-1:0] stat_grant_q, stat_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_grant_q <= '0;
            stat_stall_q <= '0;
        end else begin
            for (int i = 0; i < NrReq; i++) begin
                if (gnt[i] && !(&stat_grant_q[i])) begin
                    stat_grant_q[i] <= stat_grant_q[i] + 1'b1;
                end
                if (req_we_i[i] && !gnt[i] && !(&stat_stall_q[i])) begin
                    stat_stall_q[i] <= stat_stall_q[i] + 1'b1;
                end
            end
        end
    end

    assign stat_grant_o = stat_grant_q;
    assign stat_stall_o = stat_stall_q;
`else
    assign stat_grant_o = '0;
    assign stat_stall_o = '0;
`endif

endmodule

// File: tb/tb_spatz_vrf_wport_arbiter.sv
// Directed bench for spatz_vrf_wport_arbiter: a vector table on a 2-requester
// instance plus short sequences for starvation, wrap-around and reset.
module tb_spatz_vrf_wport_arbiter;
    import spatz_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- instance A: NrReq=2, StarveThresh=8
    logic       [1:0]       a_we, a_gnt;
    vreg_addr_t [1:0]       a_addr;
    vreg_data_t [1:0]       a_data;
    vreg_be_t   [1:0]       a_be;
    spatz_id_t  [1:0]       a_id;
    logic                   a_vv, a_vwe;
    vreg_addr_t             a_vaddr;
    vreg_data_t             a_vdata;
    vreg_be_t               a_vbe;
    spatz_id_t              a_vid;
    logic [1:0][15:0]       a_sg, a_ss;

    spatz_vrf_wport_arbiter #(.NrReq(2), .StarveThresh(8), .CntWidth(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_we_i(a_we), .req_waddr_i(a_addr),
        .req_wdata_i(a_data), .req_wbe_i(a_be), .req_id_i(a_id), .req_wvalid_o(a_gnt),
        .vrf_we_o(a_vwe), .vrf_waddr_o(a_vaddr), .vrf_wdata_o(a_vdata), .vrf_wbe_o(a_vbe),
        .vrf_id_o(a_vid), .vrf_wvalid_i(a_vv), .stat_grant_o(a_sg), .stat_stall_o(a_ss)
    );

    // ---------------- instance B: NrReq=2, StarveThresh=3
    logic       [1:0]       b_we, b_gnt;
    vreg_addr_t [1:0]       b_addr;
    vreg_data_t [1:0]       b_data;
    vreg_be_t   [1:0]       b_be;
    spatz_id_t  [1:0]       b_id;
    logic                   b_vv, b_vwe;
    vreg_addr_t             b_vaddr;
    vreg_data_t             b_vdata;
    vreg_be_t               b_vbe;
    spatz_id_t              b_vid;
    logic [1:0][15:0]       b_sg, b_ss;

    spatz_vrf_wport_arbiter #(.NrReq(2), .StarveThresh(3), .CntWidth(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .req_we_i(b_we), .req_waddr_i(b_addr),
        .req_wdata_i(b_data), .req_wbe_i(b_be), .req_id_i(b_id), .req_wvalid_o(b_gnt),
        .vrf_we_o(b_vwe), .vrf_waddr_o(b_vaddr), .vrf_wdata_o(b_vdata), .vrf_wbe_o(b_vbe),
        .vrf_id_o(b_vid), .vrf_wvalid_i(b_vv), .stat_grant_o(b_sg), .stat_stall_o(b_ss)
    );

    // ---------------- instance C: NrReq=3, StarveThresh=8
    logic       [2:0]       c_we, c_gnt;
    vreg_addr_t [2:0]       c_addr;
    vreg_data_t [2:0]       c_data;
    vreg_be_t   [2:0]       c_be;
    spatz_id_t  [2:0]       c_id;
    logic                   c_vv, c_vwe;
    vreg_addr_t             c_vaddr;
    vreg_data_t             c_vdata;
    vreg_be_t               c_vbe;
    spatz_id_t              c_vid;
    logic [2:0][15:0]       c_sg, c_ss;

    spatz_vrf_wport_arbiter #(.NrReq(3), .StarveThresh(8), .CntWidth(16)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .req_we_i(c_we), .req_waddr_i(c_addr),
        .req_wdata_i(c_data), .req_wbe_i(c_be), .req_id_i(c_id), .req_wvalid_o(c_gnt),
        .vrf_we_o(c_vwe), .vrf_waddr_o(c_vaddr), .vrf_wdata_o(c_vdata), .vrf_wbe_o(c_vbe),
        .vrf_id_o(c_vid), .vrf_wvalid_i(c_vv), .stat_grant_o(c_sg), .stat_stall_o(c_ss)
    );

    // Payload fields are derived from the address so one number identifies a write.
    function automatic vreg_data_t mkd(vreg_addr_t a);
        return {54'h0, a} ^ 64'hA5A5_5A5A_F00D_BEEF;
    endfunction
    function automatic vreg_be_t mkb(vreg_addr_t a);
        return a[7:0] ^ 8'h3C;
    endfunction
    function automatic spatz_id_t mki(vreg_addr_t a);
        return a[2:0] ^ 3'b101;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [1:0] we, input logic vv, input vreg_addr_t x0, input vreg_addr_t x1);
        a_we = we; a_vv = vv; a_addr[0] = x0; a_addr[1] = x1;
        for (int i = 0; i < 2; i++) begin
            a_data[i] = mkd(a_addr[i]); a_be[i] = mkb(a_addr[i]); a_id[i] = mki(a_addr[i]);
        end
    endtask

    task automatic drive_b(input logic [1:0] we, input logic vv, input vreg_addr_t x0, input vreg_addr_t x1);
        b_we = we; b_vv = vv; b_addr[0] = x0; b_addr[1] = x1;
        for (int i = 0; i < 2; i++) begin
            b_data[i] = mkd(b_addr[i]); b_be[i] = mkb(b_addr[i]); b_id[i] = mki(b_addr[i]);
        end
    endtask

    task automatic drive_c(input logic [2:0] we, input vreg_addr_t x0, input vreg_addr_t x1);
        c_we = we; c_vv = 1'b1; c_addr[0] = x0; c_addr[1] = x1; c_addr[2] = '0;
        for (int i = 0; i < 3; i++) begin
            c_data[i] = mkd(c_addr[i]); c_be[i] = mkb(c_addr[i]); c_id[i] = mki(c_addr[i]);
        end
    endtask

    task automatic chk_a_out(input string tag, input logic vwe, input vreg_addr_t va);
        chk({tag, "_vwe"},   64'(a_vwe),   64'(vwe));
        chk({tag, "_waddr"}, 64'(a_vaddr), vwe ? 64'(va) : 64'h0);
        chk({tag, "_wdata"}, a_vdata,      vwe ? mkd(va) : 64'h0);
        chk({tag, "_wbe"},   64'(a_vbe),   vwe ? 64'(mkb(va)) : 64'h0);
        chk({tag, "_id"},    64'(a_vid),   vwe ? 64'(mki(va)) : 64'h0);
    endtask

    typedef struct packed {
        logic [1:0] we;
        logic       vv;
        vreg_addr_t a0;
        vreg_addr_t a1;
        logic [1:0] gnt;
        logic       vwe;
        vreg_addr_t vaddr;
    } vec_t;

    localparam int NROW = 23;
    vec_t tbl [NROW];
    int   exp_g [2];
    int   exp_s [2];

    initial begin
        // Table: alternating grants, 5-cycle stall, single requester streaming, drain.
        tbl[0]  = '{we: 2'b00, vv: 1'b0, a0: 10'h000, a1: 10'h000, gnt: 2'b00, vwe: 1'b0, vaddr: 10'h000};
        tbl[1]  = '{we: 2'b11, vv: 1'b1, a0: 10'h100, a1: 10'h200, gnt: 2'b01, vwe: 1'b0, vaddr: 10'h000};
        tbl[2]  = '{we: 2'b11, vv: 1'b1, a0: 10'h101, a1: 10'h200, gnt: 2'b10, vwe: 1'b1, vaddr: 10'h100};
        tbl[3]  = '{we: 2'b11, vv: 1'b1, a0: 10'h101, a1: 10'h201, gnt: 2'b01, vwe: 1'b1, vaddr: 10'h200};
        tbl[4]  = '{we: 2'b11, vv: 1'b1, a0: 10'h102, a1: 10'h201, gnt: 2'b10, vwe: 1'b1, vaddr: 10'h101};
        for (int r = 5; r < 10; r++)
            tbl[r] = '{we: 2'b11, vv: 1'b0, a0: 10'h102, a1: 10'h202, gnt: 2'b00, vwe: 1'b1, vaddr: 10'h201};
        tbl[10] = '{we: 2'b11, vv: 1'b1, a0: 10'h102, a1: 10'h202, gnt: 2'b01, vwe: 1'b1, vaddr: 10'h201};
        for (int r = 11; r < 21; r++)
            tbl[r] = '{we: 2'b01, vv: 1'b1, a0: 10'(r - 11), a1: 10'h000, gnt: 2'b01, vwe: 1'b1,
                       vaddr: (r == 11) ? 10'h102 : 10'(r - 12)};
        tbl[21] = '{we: 2'b00, vv: 1'b1, a0: 10'h000, a1: 10'h000, gnt: 2'b00, vwe: 1'b1, vaddr: 10'h009};
        tbl[22] = '{we: 2'b00, vv: 1'b0, a0: 10'h000, a1: 10'h000, gnt: 2'b00, vwe: 1'b0, vaddr: 10'h000};
        exp_g = '{0, 0};
        exp_s = '{0, 0};

        drive_a(2'b00, 1'b0, '0, '0);
        drive_b(2'b00, 1'b0, '0, '0);
        drive_c(3'b000, '0, '0);
        c_vv = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk);
        #3;
        chk_a_out("rst", 1'b0, '0);
        chk("rst_gnt", 64'(a_gnt), 64'h0);
        chk("rst_stat_g", 64'(a_sg), 64'h0);
        chk("rst_stat_s", 64'(a_ss), 64'h0);
        step();
        rst_n = 1'b1;

        // ---- vector table on instance A
        for (int r = 0; r < NROW; r++) begin
            drive_a(tbl[r].we, tbl[r].vv, tbl[r].a0, tbl[r].a1);
            #3;
            chk($sformatf("v%0d_gnt", r), 64'(a_gnt), 64'(tbl[r].gnt));
            chk_a_out($sformatf("v%0d", r), tbl[r].vwe, tbl[r].vaddr);
            for (int i = 0; i < 2; i++) begin
                if (tbl[r].gnt[i]) exp_g[i]++;
                if (tbl[r].we[i] && !tbl[r].gnt[i]) exp_s[i]++;
            end
            step();
        end
`ifdef SPATZ_VRF_ARB_STATS_EN
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("stat_grant%0d", i), 64'(a_sg[i]), 64'(exp_g[i]));
            chk($sformatf("stat_stall%0d", i), 64'(a_ss[i]), 64'(exp_s[i]));
        end
`else
        chk("stat_grant_off", 64'(a_sg), 64'h0);
        chk("stat_stall_off", 64'(a_ss), 64'h0);
`endif

        // ---- reset while the output register is full (rr_ptr is 1 here)
        drive_a(2'b01, 1'b1, 10'h055, '0);
        #3;
        chk("mr_gnt", 64'(a_gnt), 64'h1);
        step();
        drive_a(2'b00, 1'b0, '0, '0);
        chk_a_out("mr_full", 1'b1, 10'h055);
        rst_n = 1'b0;
        #1;
        chk_a_out("mr_rst", 1'b0, '0);
        step();
        step();
        rst_n = 1'b1;
        drive_a(2'b11, 1'b1, 10'h060, 10'h070);
        #3;
        chk("mr_rrptr", 64'(a_gnt), 64'h1);
        chk("mr_stat_g", 64'(a_sg), 64'h0);
        chk("mr_stat_s", 64'(a_ss), 64'h0);
        step();
        drive_a(2'b00, 1'b1, '0, '0);
        #3;
        chk_a_out("mr_after", 1'b1, 10'h060);
        step();

        // ---- starvation override on instance B (threshold 3)
        drive_b(2'b10, 1'b1, '0, 10'h031);
        #3;
        chk("sv_g1", 64'(b_gnt), 64'h2);
        step();
        for (int k = 0; k < 3; k++) begin
            drive_b(2'b10, 1'b0, '0, 10'h032);
            #3;
            chk($sformatf("sv_stall%0d", k), 64'(b_gnt), 64'h0);
            chk($sformatf("sv_hold%0d", k), 64'(b_vaddr), 64'h031);
            step();
        end
        drive_b(2'b11, 1'b1, 10'h040, 10'h032);
        #3;
        chk("sv_starved_wins", 64'(b_gnt), 64'h2);
        step();
        drive_b(2'b01, 1'b1, 10'h040, '0);
        #3;
        chk("sv_next", 64'(b_gnt), 64'h1);
        chk("sv_next_addr", 64'(b_vaddr), 64'h032);
        step();
        drive_b(2'b00, 1'b1, '0, '0);
        #3;
        chk("sv_last_addr", 64'(b_vaddr), 64'h040);
        step();

        // ---- wrap-around on instance C (3 requesters)
        drive_c(3'b010, '0, 10'h011);
        #3;
        chk("wr_g1", 64'(c_gnt), 64'h2);
        step();
        drive_c(3'b011, 10'h020, 10'h012);
        #3;
        chk("wr_wrap", 64'(c_gnt), 64'h1);
        chk("wr_addr1", 64'(c_vaddr), 64'h011);
        step();
        drive_c(3'b011, 10'h021, 10'h012);
        #3;
        chk("wr_rr1", 64'(c_gnt), 64'h2);
        chk("wr_addr2", 64'(c_vaddr), 64'h020);
        step();
        drive_c(3'b001, 10'h021, '0);
        #3;
        chk("wr_rr2", 64'(c_gnt), 64'h1);
        chk("wr_addr3", 64'(c_vaddr), 64'h012);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
